// File: rtl/gpnae_pkg.sv
// Shared types for the gpnae feeder: FSM state encoding
// and the operation codes carried on the control word.
package gpnae_pkg;

  typedef enum logic [2:0] {
    FD_IDLE,
    FD_LOAD,
    FD_SEND,
    FD_WAIT,
    FD_RESULT
  } feeder_state_e;

  localparam logic [1:0] CTRL_SELU    = 2'b01;
  localparam logic [1:0] CTRL_SIGMOID = 2'b10;
  localparam logic [1:0] CTRL_TANH    = 2'b11;

endpackage

// File: rtl/gpnae_feeder_buf.sv
// Sample buffer for the gpnae feeder: one synchronous
// write port, one combinational read port, no reset.
module gpnae_feeder_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_LINES = 5
) (
  input  logic                  clk_i,
  input  logic                  we,
  input  logic [ADDR_LINES-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [ADDR_LINES-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  localparam int DEPTH = 1 << ADDR_LINES;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/gpnae_feeder.sv
// Stream source for the gpnae engine: buffer, replay, await result.
// Optional done-wait timeout: define GPNAE_FEEDER_TIMEOUT_EN.
module gpnae_feeder
  import gpnae_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_LINES     = 5,
  parameter int CONTROL_WIDTH  = 2,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     start_i,
  input  logic [CONTROL_WIDTH-1:0] control_word_i,
  output logic                     busy_o,
  input  logic [DATA_WIDTH-1:0]    load_data_i,
  input  logic                     load_valid_i,
  input  logic                     load_last_i,
  output logic                     load_ready_o,
  output logic [DATA_WIDTH-1:0]    sig_o,
  output logic                     wr_en_o,
  output logic                     last_o,
  output logic [ADDR_LINES-1:0]    terms_o,
  output logic [CONTROL_WIDTH-1:0] ctrl_o,
  input  logic                     full_i,
  input  logic                     done_i,
  input  logic [DATA_WIDTH-1:0]    result_i,
  output logic [DATA_WIDTH-1:0]    res_data_o,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic                     res_error_o
);

  feeder_state_e state_q, state_d;

  logic [ADDR_LINES-1:0]    wptr_q;
  logic [ADDR_LINES-1:0]    rptr_q;
  logic [ADDR_LINES-1:0]    terms_q;
  logic [CONTROL_WIDTH-1:0] ctrl_q;
  logic [DATA_WIDTH-1:0]    res_data_q;
  logic [DATA_WIDTH-1:0]    rd_data;

  logic load_hs;
  logic load_end;
  logic send_end;
  logic timeout;

  assign load_hs  = load_valid_i && load_ready_o;
  assign load_end = load_hs && (load_last_i || (&wptr_q));
  assign send_end = wr_en_o && (rptr_q == terms_q);

  gpnae_feeder_buf #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_LINES(ADDR_LINES)
  ) u_buf (
    .clk_i(clk_i),
    .we   (load_hs),
    .waddr(wptr_q),
    .wdata(load_data_i),
    .raddr(rptr_q),
    .rdata(rd_data)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= FD_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FD_IDLE:   if (start_i) state_d = FD_LOAD;
      FD_LOAD:   if (load_end) state_d = FD_SEND;
      FD_SEND:   if (send_end) state_d = FD_WAIT;
      FD_WAIT:   if (done_i || timeout) state_d = FD_RESULT;
      FD_RESULT: if (res_ready_i) state_d = FD_IDLE;
      default:   state_d = FD_IDLE;
    endcase
  end

  always_comb begin
    busy_o       = (state_q != FD_IDLE);
    load_ready_o = (state_q == FD_LOAD);
    wr_en_o      = (state_q == FD_SEND) && !full_i;
    sig_o        = '0;
    if (state_q == FD_SEND) sig_o = rd_data;
    last_o       = wr_en_o && (rptr_q == terms_q);
    res_valid_o  = (state_q == FD_RESULT);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      terms_q <= '0;
      ctrl_q  <= '0;
    end else begin
      unique case (state_q)
        FD_IDLE: begin
          wptr_q <= '0;
          rptr_q <= '0;
          if (start_i) ctrl_q <= control_word_i;
        end
        FD_LOAD: begin
          if (load_hs) wptr_q <= wptr_q + 1'b1;
          // N-1 is simply the address of the final sample
          if (load_end) terms_q <= wptr_q;
        end
        FD_SEND: begin
          if (wr_en_o) rptr_q <= rptr_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign terms_o = terms_q;
  assign ctrl_o  = ctrl_q;

`ifdef GPNAE_FEEDER_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;

  logic [TW-1:0] to_cnt_q;
  logic          res_err_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || state_q != FD_WAIT) to_cnt_q <= '0;
    else                             to_cnt_q <= to_cnt_q + 1'b1;
  end

  assign timeout = (state_q == FD_WAIT) &&
                   (to_cnt_q == TW'(TIMEOUT_CYCLES - 1));

  // done_i takes priority over a coincident timeout
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      res_data_q <= '0;
      res_err_q  <= 1'b0;
    end else if (state_q == FD_WAIT) begin
      if (done_i) begin
        res_data_q <= result_i;
        res_err_q  <= 1'b0;
      end else if (timeout) begin
        res_data_q <= '0;
        res_err_q  <= 1'b1;
      end
    end
  end

  assign res_error_o = res_err_q;
`else
  logic unused_timeout;

  assign unused_timeout = (TIMEOUT_CYCLES == 0);
  assign timeout        = 1'b0;

  always_ff @(posedge clk_i) begin
    if (rst_i) res_data_q <= '0;
    else if (state_q == FD_WAIT && done_i)
      res_data_q <= result_i;
  end

  assign res_error_o = 1'b0;
`endif

  assign res_data_o = res_data_q;

endmodule

// File: tb/tb_gpnae_feeder.sv
// Directed bench for gpnae_feeder: load, replay with stalls,
// forced last, result backpressure, mid-send reset, timeout.
module tb_gpnae_feeder;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        start_i = 1'b0;
  logic [1:0]  control_word_i = '0;
  logic        busy_o;
  logic [31:0] load_data_i = '0;
  logic        load_valid_i = 1'b0;
  logic        load_last_i = 1'b0;
  logic        load_ready_o;
  logic [31:0] sig_o;
  logic        wr_en_o;
  logic        last_o;
  logic [4:0]  terms_o;
  logic [1:0]  ctrl_o;
  logic        full_i = 1'b0;
  logic        done_i = 1'b0;
  logic [31:0] result_i = '0;
  logic [31:0] res_data_o;
  logic        res_valid_o;
  logic        res_ready_i = 1'b0;
  logic        res_error_o;

  int total = 0;
  int bad   = 0;

  logic [31:0] smp [32];

  gpnae_feeder #(
    .DATA_WIDTH    (32),
    .ADDR_LINES    (5),
    .CONTROL_WIDTH (2),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .start_i       (start_i),
    .control_word_i(control_word_i),
    .busy_o        (busy_o),
    .load_data_i   (load_data_i),
    .load_valid_i  (load_valid_i),
    .load_last_i   (load_last_i),
    .load_ready_o  (load_ready_o),
    .sig_o         (sig_o),
    .wr_en_o       (wr_en_o),
    .last_o        (last_o),
    .terms_o       (terms_o),
    .ctrl_o        (ctrl_o),
    .full_i        (full_i),
    .done_i        (done_i),
    .result_i      (result_i),
    .res_data_o    (res_data_o),
    .res_valid_o   (res_valid_o),
    .res_ready_i   (res_ready_i),
    .res_error_o   (res_error_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_zero();
    chk("z_busy", 32'(busy_o), 0);
    chk("z_ldrdy", 32'(load_ready_o), 0);
    chk("z_wren", 32'(wr_en_o), 0);
    chk("z_last", 32'(last_o), 0);
    chk("z_rvalid", 32'(res_valid_o), 0);
    chk("z_rerr", 32'(res_error_o), 0);
    chk("z_sig", sig_o, 0);
    chk("z_terms", 32'(terms_o), 0);
    chk("z_ctrl", 32'(ctrl_o), 0);
    chk("z_rdata", res_data_o, 0);
  endtask

  task automatic do_start(input logic [1:0] cw);
    start_i = 1'b1;
    control_word_i = cw;
    #1;
    chk("idle_busy", 32'(busy_o), 0);
    step();
    start_i = 1'b0;
    control_word_i = ~cw;
    chk("load_busy", 32'(busy_o), 1);
    chk("load_rdy", 32'(load_ready_o), 1);
  endtask

  task automatic do_load(input int n, input bit use_last);
    for (int i = 0; i < n; i++) begin
      load_data_i  = smp[i];
      load_valid_i = 1'b1;
      load_last_i  = use_last && (i == n - 1);
      #1;
      chk("ld_rdy", 32'(load_ready_o), 1);
      chk("ld_wren", 32'(wr_en_o), 0);
      step();
    end
    load_valid_i = 1'b0;
    load_last_i  = 1'b0;
    load_data_i  = 32'hDEAD_BEEF;
  endtask

  task automatic do_send(input int n, input logic [31:0] fmask,
                         input logic [1:0] cw);
    int w = 0;
    int cyc = 0;
    int stalls = $countones(fmask);
    while (w < n && cyc < n + stalls + 4) begin
      full_i = fmask[cyc[4:0]] && (cyc < 32);
      #1;
      chk("snd_wren", 32'(wr_en_o), 32'(!full_i));
      chk("snd_sig", sig_o, smp[w]);
      chk("snd_last", 32'(last_o),
          32'(!full_i && (w == n - 1)));
      if (wr_en_o) w++;
      step();
      cyc++;
    end
    full_i = 1'b0;
    chk("snd_writes", 32'(w), 32'(n));
    chk("snd_cycles", 32'(cyc), 32'(n + stalls));
    chk("snd_terms", 32'(terms_o), 32'(n - 1));
    chk("snd_ctrl", 32'(ctrl_o), 32'(cw));
    #1;
    chk("wait_wren", 32'(wr_en_o), 0);
    chk("wait_busy", 32'(busy_o), 1);
  endtask

  task automatic do_result(input logic [31:0] r, input int dly);
    step();
    chk("wait_rvalid", 32'(res_valid_o), 0);
    done_i   = 1'b1;
    result_i = r;
    step();
    done_i   = 1'b0;
    result_i = 32'h1234_5678;
    for (int k = 0; k <= dly; k++) begin
      res_ready_i = (k == dly);
      #1;
      chk("res_valid", 32'(res_valid_o), 1);
      chk("res_data", res_data_o, r);
      chk("res_err", 32'(res_error_o), 0);
      step();
    end
    res_ready_i = 1'b0;
    chk("post_busy", 32'(busy_o), 0);
    chk("post_rvalid", 32'(res_valid_o), 0);
  endtask

  initial begin
    step();
    step();
    chk_zero();
    rst_i = 1'b0;
    step();

    // stray done/valid in IDLE must be ignored
    done_i = 1'b1;
    load_valid_i = 1'b1;
    step();
    done_i = 1'b0;
    load_valid_i = 1'b0;
    chk("idle_ign_busy", 32'(busy_o), 0);
    chk("idle_ign_rv", 32'(res_valid_o), 0);

    smp[0] = 32'h3F80_0000;
    smp[1] = 32'h4000_0000;
    smp[2] = 32'hBF80_0000;
    smp[3] = 32'h0000_0000;

    // job 1: plain 4-sample vector
    do_start(2'b10);
    do_load(4, 1'b1);
    do_send(4, 32'h0, 2'b10);
    do_result(32'h3F3B_26A0, 3);

    // job 2: back-to-back, full on SEND cycles 2-4
    do_start(2'b10);
    do_load(4, 1'b1);
    do_send(4, 32'hE, 2'b10);
    do_result(32'h0BAD_F00D, 0);

    // job 3: 32 samples, no load_last
    for (int i = 0; i < 32; i++)
      smp[i] = 32'h0101_0101 * i + 32'h7;
    do_start(2'b11);
    do_load(32, 1'b0);
    do_send(32, 32'h0, 2'b11);
    do_result(32'h4242_0001, 1);

    // job 4: reset on the 2nd write of SEND
    smp[0] = 32'hA000_0001;
    smp[1] = 32'hA000_0002;
    smp[2] = 32'hA000_0003;
    do_start(2'b01);
    do_load(3, 1'b1);
    #1;
    chk("rst_w1", 32'(wr_en_o), 1);
    step();
    rst_i = 1'b1;
    #1;
    chk("rst_w2", 32'(wr_en_o), 1);
    chk("rst_s2", sig_o, smp[1]);
    step();
    rst_i = 1'b0;
    chk_zero();
    step();

    // job 5: fresh job after reset
    smp[0] = 32'h5555_0000;
    smp[1] = 32'h6666_1111;
    do_start(2'b01);
    do_load(2, 1'b1);
    do_send(2, 32'h1, 2'b01);
    do_result(32'hCAFE_0005, 0);

`ifdef GPNAE_FEEDER_TIMEOUT_EN
    begin
      int k = 0;
      do_start(2'b11);
      do_load(2, 1'b1);
      do_send(2, 32'h0, 2'b11);
      while (!res_valid_o && k < 40) begin
        step();
        k++;
      end
      chk("to_cycles", 32'(k), 32'd16);
      chk("to_valid", 32'(res_valid_o), 1);
      chk("to_err", 32'(res_error_o), 1);
      chk("to_data", res_data_o, 0);
      res_ready_i = 1'b1;
      step();
      res_ready_i = 1'b0;
      chk("to_idle", 32'(busy_o), 0);
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
